// File: rtl/lsu_split_ctrl.sv
// Load/store unit: byte/half/word accesses on a req/gnt/rvalid bus, splitting misaligned ones in two.
// Optional: define LSU_TIMEOUT_EN to abort a bus wait after TIMEOUT_CYC cycles with an error.
module lsu_split_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [1:0]            lsu_type_i,
  input  logic                  lsu_sign_ext_i,
  input  logic [ADDR_W-1:0]     lsu_addr_i,
  input  logic [31:0]           lsu_wdata_i,
  output logic                  lsu_busy_o,
  output logic                  lsu_resp_valid_o,
  output logic [31:0]           lsu_rdata_o,
  output logic                  lsu_err_o,
  output logic                  data_req_o,
  output logic                  data_we_o,
  output logic [DATA_W/8-1:0]   data_be_o,
  output logic [ADDR_W-1:0]     data_addr_o,
  output logic [DATA_W-1:0]     data_wdata_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic [DATA_W-1:0]     data_rdata_i,
  input  logic                  data_err_i
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP} state_t;
  state_t state_q, state_d;

  logic              we_q, sign_q;
  logic [1:0]        type_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [DATA_W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              resp_err_q, resp_err_d;

  logic [OFF_W-1:0]    off;
  logic [BE_W-1:0]     size_mask;
  logic [2*BE_W-1:0]   be_wide;
  logic [2*DATA_W-1:0] wdata_wide;
  logic [ADDR_W-1:0]   base_addr;
  logic                split;
  logic [31:0]         rd_shift, load_val;
  logic                timeout;

  assign off        = addr_q[OFF_W-1:0];
  assign base_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  // Two-beat windows: the low half feeds the first transaction, the high half the second.
  assign be_wide    = {{BE_W{1'b0}}, size_mask} << off;
  assign wdata_wide = {{(2*DATA_W-32){1'b0}}, wdata_q} << {off, 3'b000};
  assign split      = |be_wide[2*BE_W-1:BE_W];
  assign rd_shift   = 32'({hi_d, lo_d} >> {off, 3'b000});

  always_comb begin
    size_mask = '0;
    case (type_q)
      2'b00:   size_mask[0]   = 1'b1;
      2'b01:   size_mask[1:0] = 2'b11;
      default: size_mask[3:0] = 4'hF;
    endcase
  end

  always_comb begin
    case (type_q)
      2'b00:   load_val = {{24{sign_q & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_val = {{16{sign_q & rd_shift[15]}}, rd_shift[15:0]};
      default: load_val = rd_shift;
    endcase
  end

  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (data_rvalid_i && state_q == WAIT1) lo_d = data_rdata_i;
    if (data_rvalid_i && state_q == WAIT2) hi_d = data_rdata_i;
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Leaving a wait state always passes through REQ*/RESP/IDLE, which clears the count.
  always_comb begin
    cnt_d = '0;
    if (state_q == WAIT1 || state_q == WAIT2) cnt_d = cnt_q + 1'b1;
  end
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    resp_err_d = resp_err_q;
    case (state_q)
      IDLE: if (lsu_req_i) begin
        state_d = REQ1;
        err_d   = 1'b0;
      end
      REQ1: if (data_gnt_i) state_d = WAIT1;
      WAIT1: begin
        if (data_rvalid_i) begin
          err_d   = err_q | data_err_i;
          state_d = (split && !data_err_i) ? REQ2 : RESP;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      REQ2: if (data_gnt_i) state_d = WAIT2;
      WAIT2: begin
        if (data_rvalid_i) begin
          err_d   = err_q | data_err_i;
          state_d = RESP;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Response values are registered on entry to RESP and then held until the next one.
    if (state_d == RESP && state_q != RESP) begin
      rdata_d    = we_q ? 32'h0 : load_val;
      resp_err_d = err_d;
    end
  end

  always_comb begin
    data_req_o   = 1'b0;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_addr_o  = '0;
    data_wdata_o = '0;
    if (state_q == REQ1) begin
      data_req_o   = 1'b1;
      data_we_o    = we_q;
      data_be_o    = be_wide[BE_W-1:0];
      data_addr_o  = base_addr;
      data_wdata_o = wdata_wide[DATA_W-1:0];
    end else if (state_q == REQ2) begin
      data_req_o   = 1'b1;
      data_we_o    = we_q;
      data_be_o    = be_wide[2*BE_W-1:BE_W];
      data_addr_o  = base_addr + ADDR_W'(BE_W);
      data_wdata_o = wdata_wide[2*DATA_W-1:DATA_W];
    end
  end

  assign lsu_busy_o       = (state_q != IDLE);
  assign lsu_resp_valid_o = (state_q == RESP);
  assign lsu_rdata_o      = rdata_q;
  assign lsu_err_o        = resp_err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      sign_q     <= 1'b0;
      type_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      resp_err_q <= resp_err_d;
      if (state_q == IDLE && lsu_req_i) begin
        we_q    <= lsu_we_i;
        sign_q  <= lsu_sign_ext_i;
        type_q  <= lsu_type_i;
        addr_q  <= lsu_addr_i;
        wdata_q <= lsu_wdata_i;
      end
    end
  end
endmodule
